bitwise_unit: RTL and testbench
===============================

BITWISE_UNIT -- requirements
Module: bitwise_unit

Interface
REQ-001 Parameter WIDTH, default 4, sets the operand and result width in bits (legal values 1 to 64).
REQ-002 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  is the reset, asynchronous and active-low.
REQ-004 Port a  input  WIDTH  is operand A.
REQ-005 Port b  input  WIDTH  is operand B (ignored for NOT and PASS).
REQ-006 Port op  input  3  is the operation select (see REQ-011).
REQ-007 Port in_valid  input  1  means a, b and op hold a request.
REQ-008 Port in_ready  output  1  means the block accepts a request this cycle.
REQ-009 Port out_valid, out_ready, and result (WIDTH bits) form the output handshake, with out_valid and result outputs and out_ready an input.
REQ-010 Ports out_zero  output  1 and out_parity  output  1 exist only when BITWISE_FLAGS_EN is defined (REQ-026).

Function
REQ-011 op decode SHALL be: 000 NOT a, 001 a AND b, 010 a OR b, 011 a XOR b, 100 NAND, 101 NOR, 110 XNOR, 111 PASS a; all bitwise over WIDTH bits, no carry or sign handling.
REQ-012 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; the result is computed from a, b and op sampled at that edge.
REQ-013 Results SHALL be held in a 2-entry in-order output buffer; count ranges 0..2.
REQ-014 in_ready SHALL be 1 when count < 2 and SHALL depend only on registered state, never on in_valid or out_ready.
REQ-015 out_valid SHALL be 1 when count > 0; result SHALL show the oldest entry; an entry is popped on an edge with out_valid and out_ready both 1.
REQ-016 Latency SHALL be 1 cycle: a request accepted at edge N with an empty buffer gives out_valid=1 and the correct result after edge N.
REQ-017 A push and a pop on the same edge SHALL leave count unchanged and keep order; with count 1 the new entry becomes the head after the pop.
REQ-018 At count 2, in_ready SHALL be 0; a pop at that edge drops count to 1 and raises in_ready for the next cycle only.
REQ-019 While out_valid=1 and out_ready=0, result (and flags) SHALL stay stable.
REQ-020 Full throughput SHALL be kept: with out_ready held at 1, one result per cycle and no bubbles.
REQ-021 in_valid while in_ready=0 SHALL be ignored, with no state change.
REQ-022 Illegal op values cannot occur because all 8 codes are defined; X on op when in_valid=0 SHALL NOT change state.

Reset
REQ-023 When rst_n is low, count, read/write pointers and all stored entries SHALL clear to 0 at once, without waiting for clk.
REQ-024 During reset and on the first cycle after it: out_valid=0, in_ready=1, result=0, out_zero=0, out_parity=0.
REQ-025 Reset while entries are held SHALL discard them; no partial result is output after reset is released.

Configuration
REQ-026 Macro BITWISE_FLAGS_EN, when defined, SHALL add out_zero (1 when the head result is all zeros) and out_parity (XOR-reduce of the head result), stored per entry and aligned with result.
REQ-027 Without BITWISE_FLAGS_EN, the flag ports and storage SHALL be absent; all other behaviour is the same.

Verification
REQ-028 WIDTH=4, after reset, op=000 a=4'b1010 with out_ready=1 -> one cycle later out_valid=1, result=4'b0101, then out_valid=0.
REQ-029 WIDTH=4, back-to-back ops AND(1100,1010), XOR(1100,1010), NOR(1100,1010) with out_ready=1 -> results 1000, 0110, 0001 on three consecutive cycles.
REQ-030 out_ready=0, present 3 requests -> first two accepted, in_ready=0 on third; raise out_ready -> results in order, third accepted the cycle after the first pop.
REQ-031 count=1 with push and pop on the same edge -> count stays 1, result shows the newer entry, order kept.
REQ-032 Assert rst_n low mid-stream with count=2 -> out_valid drops to 0 with no clock edge; after release in_ready=1 and no stale result.
REQ-033 BITWISE_FLAGS_EN defined, WIDTH=8, XNOR(0xF0,0x0F) -> result=0x00, out_zero=1, out_parity=0; PASS 0x07 -> out_zero=0, out_parity=1.

Source files
------------

// File: rtl/bitwise_unit.sv
// Bitwise ALU (NOT/AND/OR/XOR/NAND/NOR/XNOR/PASS) feeding a 2-entry in-order result buffer; BITWISE_FLAGS_EN adds zero/parity flags.
// Latency 1 cycle; in_ready is registered-only (count < 2), result/flags held stable while out_ready is low.
module bitwise_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef BITWISE_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  logic [1:0]       count_q, count_d;
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic [WIDTH-1:0] res;
  logic             push, pop;

  always_comb begin
    case (op)
      3'b000:  res = ~a;
      3'b001:  res = a & b;
      3'b010:  res = a | b;
      3'b011:  res = a ^ b;
      3'b100:  res = ~(a & b);
      3'b101:  res = ~(a | b);
      3'b110:  res = ~(a ^ b);
      default: res = a;
    endcase
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign result    = mem_q[rptr_q];

  // Accept is gated by in_valid, so an undriven op while idle never reaches storage.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wptr_q] = res;
      wptr_d        = ~wptr_q;
    end
    if (pop) begin
      rptr_d = ~rptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

`ifdef BITWISE_FLAGS_EN
  logic [1:0] zero_q, zero_d;
  logic [1:0] par_q, par_d;

  // Flags are computed at accept time and stored beside the result so they stay aligned.
  always_comb begin
    zero_d = zero_q;
    par_d  = par_q;
    if (push) begin
      zero_d[wptr_q] = ~|res;
      par_d[wptr_q]  = ^res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 2'b00;
      par_q  <= 2'b00;
    end else begin
      zero_q <= zero_d;
      par_q  <= par_d;
    end
  end

  assign out_zero   = zero_q[rptr_q];
  assign out_parity = par_q[rptr_q];
`endif

endmodule

// File: tb/tb_bitwise_unit.sv
// Directed + random bench for bitwise_unit with a queue scoreboard of expected {zero, parity, result}.
module tb_bitwise_unit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = 3'b000;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
`ifdef BITWISE_FLAGS_EN
  logic         out_zero, out_parity;
`endif

  int checks = 0;
  int errors = 0;
  logic [W+1:0] sb [$];

  bitwise_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef BITWISE_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    case (o)
      3'b000:  r = ~x;
      3'b001:  r = x & y;
      3'b010:  r = x | y;
      3'b011:  r = x ^ y;
      3'b100:  r = ~(x & y);
      3'b101:  r = ~(x | y);
      3'b110:  r = ~(x ^ y);
      default: r = x;
    endcase
    return {~|r, ^r, r};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_result"}, result, '0);
`ifdef BITWISE_FLAGS_EN
    check({tag, "_zero"}, out_zero, 1'b0);
    check({tag, "_parity"}, out_parity, 1'b0);
`endif
  endtask

  // Check current outputs against the scoreboard, then advance one edge and update it.
  task automatic tick();
    bit pop_e, push_e;
    logic [W+1:0] exp_e;
    check("out_valid", out_valid, sb.size() > 0);
    check("in_ready", in_ready, sb.size() < 2);
    if (sb.size() > 0) begin
      check("result", result, sb[0][W-1:0]);
`ifdef BITWISE_FLAGS_EN
      check("out_zero", out_zero, sb[0][W+1]);
      check("out_parity", out_parity, sb[0][W]);
`endif
    end
    pop_e  = out_ready && (sb.size() > 0);
    push_e = in_valid && (sb.size() < 2);
    exp_e  = model(op, a, b);
    @(posedge clk);
    #1;
    if (pop_e) void'(sb.pop_front());
    if (push_e) sb.push_back(exp_e);
  endtask

  task automatic req(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_state("in_reset");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check_reset_state("post_reset");

    // Single NOT, one-cycle latency
    out_ready = 1'b1;
    req(3'b000, 4'b1010, 4'b0000);
    tick();
    in_valid = 1'b0;
    check("not_result", result, 4'b0101);
    check("not_valid", out_valid, 1'b1);
    tick();
    check("not_drained", out_valid, 1'b0);

    // Back-to-back AND, XOR, NOR
    req(3'b001, 4'b1100, 4'b1010);
    tick();
    check("and_result", result, 4'b1000);
    req(3'b011, 4'b1100, 4'b1010);
    tick();
    check("xor_result", result, 4'b0110);
    req(3'b101, 4'b1100, 4'b1010);
    tick();
    in_valid = 1'b0;
    check("nor_result", result, 4'b0001);
    tick();
    check("b2b_drained", out_valid, 1'b0);

    // Backpressure: fill, third stalls, then drain in order
    out_ready = 1'b0;
    req(3'b010, 4'b0001, 4'b0010);
    tick();
    req(3'b100, 4'b1111, 4'b0110);
    tick();
    req(3'b110, 4'b0101, 4'b0011);
    check("full_in_ready", in_ready, 1'b0);
    tick();
    check("stall_result", result, 4'b0011);
    out_ready = 1'b1;
    tick();
    check("after_pop_ready", in_ready, 1'b1);
    check("after_pop_result", result, 4'b1001);
    tick();
    in_valid = 1'b0;
    check("third_result", result, 4'b1001);
    tick();
    tick();
    check("bp_drained", out_valid, 1'b0);

    // Count 1 with simultaneous push and pop
    out_ready = 1'b0;
    req(3'b111, 4'b0110, 4'b0000);
    tick();
    out_ready = 1'b1;
    req(3'b000, 4'b0011, 4'b0000);
    tick();
    in_valid = 1'b0;
    check("pushpop_valid", out_valid, 1'b1);
    check("pushpop_result", result, 4'b1100);
    tick();
    check("pushpop_drained", out_valid, 1'b0);

    // Unknown op while idle must not disturb state
    op = 3'bxxx;
    a = 'x;
    repeat (3) tick();

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    req(3'b001, 4'b1111, 4'b1111);
    tick();
    req(3'b010, 4'b1000, 4'b0001);
    tick();
    in_valid = 1'b0;
    check("pre_reset_full", in_ready, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_reset_state("async_reset");
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 check_reset_state("after_async_reset");
    repeat (2) tick();

`ifdef BITWISE_FLAGS_EN
    out_ready = 1'b1;
    req(3'b110, 4'b1100, 4'b0011);
    tick();
    req(3'b111, 4'b0111, 4'b0000);
    check("xnor_zero", out_zero, 1'b1);
    check("xnor_parity", out_parity, 1'b0);
    tick();
    in_valid = 1'b0;
    check("pass_zero", out_zero, 1'b0);
    check("pass_parity", out_parity, 1'b1);
    tick();
`endif

    // Streaming at full rate, then random traffic and backpressure
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req(3'($urandom), W'($urandom), W'($urandom));
      tick();
      check("stream_valid", out_valid, 1'b1);
    end
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      op = 3'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("final_empty", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
